// File: rtl/fop_pkg.sv
// fop_pkg: shared state encoding and default evaluator width for the fop blocks
//   FOP_N   : default evaluator input width
//   state_t : scanner FSM state encoding
package fop_pkg;
    localparam int FOP_N = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/fop_higher_any.sv
// fop_higher_any: flags whether any truth-table bit strictly above ptr is set
//   tt  : truth table, bit k = f(k)
//   ptr : current index
//   any : 1 when some tt[k] with k > ptr is set
module fop_higher_any #(
    parameter int N = fop_pkg::FOP_N
) (
    input  logic [(1<<N)-1:0] tt,
    input  logic [N-1:0]      ptr,
    output logic              any
);
    logic [(1<<N)-1:0] sh;
    assign sh  = tt >> ptr;
    assign any = |sh[(1<<N)-1:1];
endmodule

// File: rtl/fop_minterm_scan.sv
// fop_minterm_scan: sweeps an external evaluator, records its truth table and streams the true minterms
//   clk, rst_n          : clock, async active-low reset
//   start               : one-cycle request, honoured in IDLE only
//   probe / probe_out   : code driven to the evaluator and its combinational response
//   m_valid/m_ready     : minterm stream handshake, m_data index, m_last on highest true minterm
//   truth_table, count  : recorded function and number of true minterms
//   busy, done          : activity flag and one-cycle completion pulse
module fop_minterm_scan #(
    parameter int N = fop_pkg::FOP_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N-1:0]      probe,
    input  logic              probe_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N-1:0]      m_data,
    output logic              m_last,
    output logic [(1<<N)-1:0] truth_table,
    output logic [N:0]        count,
    output logic              busy,
    output logic              done
);
    import fop_pkg::*;
    localparam logic [N-1:0] TOP = {N{1'b1}};
    state_t       state, state_nx;
    logic [N-1:0] ptr;
    logic         higher, adv;
    fop_higher_any #(.N(N)) u_higher (
        .tt (truth_table),
        .ptr(ptr),
        .any(higher)
    );
    assign m_valid = (state == EMIT) && truth_table[ptr];
    assign m_data  = ptr;
    assign m_last  = m_valid && !higher;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    // empty slots are skipped at one per cycle; a true slot waits for the consumer
    assign adv     = !m_valid || m_ready;
    always_comb begin
        state_nx = state == IDLE ? (start ? SCAN : IDLE)
                 : state == SCAN ? (probe == TOP ? EMIT : SCAN)
                 : state == EMIT ? ((adv && ptr == TOP) ? DONE : EMIT)
                 : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            probe       <= '0;
            truth_table <= '0;
            count       <= '0;
            ptr         <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                probe       <= '0;
                truth_table <= '0;
                count       <= '0;
            end
            if (state == SCAN) begin
                truth_table[probe] <= probe_out;
                count              <= count + (N+1)'(probe_out);
                if (probe == TOP) ptr <= '0;
                else probe <= probe + 1'b1;
            end
            if (state == EMIT && adv) ptr <= ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_fop_minterm_scan.sv
// tb_fop_minterm_scan: randomized self-checking bench against a minterm-list reference model
module tb_fop_minterm_scan;
    localparam int N = 4;
    localparam int D = 1 << N;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         m_ready = 1'b1;
    logic [N-1:0] probe, m_data;
    logic         probe_out, m_valid, m_last, busy, done;
    logic [D-1:0] truth_table;
    logic [N:0]   count;
    logic [D-1:0] fn = '0;
    int n_chk = 0;
    int n_ok = 0;

    fop_minterm_scan #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .probe(probe), .probe_out(probe_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .truth_table(truth_table), .count(count), .busy(busy), .done(done)
    );

    // external evaluator: combinational lookup of the function under test
    assign probe_out = fn[probe];
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 ready low for 3 cycles while index 5 is offered
    task automatic run(input logic [D-1:0] f, input int rmode, input bit inj, input bit abort);
        int  q[$];
        int  idx, cyc, stalls, held;
        bit  fin;
        for (int k = 0; k < D; k++) if (f[k]) q.push_back(k);
        fn = f;
        idx = 0; cyc = 0; stalls = 0; held = 0; fin = 0;
        @(negedge clk);
        start = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = inj && (cyc == 5 || cyc == 20);
            chk("busy", busy, 1);
            if (cyc <= D) chk("probe", probe, cyc - 1);
            if (abort && cyc > D && m_data == 6) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ctl", {m_valid, m_data, m_last, busy, done, probe}, 0);
                chk("rst_dat", {truth_table, count}, 0);
                start = 1'b0;
                m_ready = 1'b1;
                @(posedge clk);
                #2 rst_n = 1'b1;
                return;
            end
            m_ready = rmode == 0 ? 1'b1 :
                      rmode == 1 ? 1'($urandom_range(0, 1)) :
                      !(m_valid && m_data == 5 && held < 3);
            if (rmode == 2 && !m_ready) held++;
            if (m_valid) begin
                chk("extra_valid", idx < q.size(), 1);
                if (idx < q.size()) begin
                    chk("m_data", m_data, q[idx]);
                    chk("m_last", m_last, idx == q.size() - 1);
                end
                if (m_ready) idx++;
                else stalls++;
            end
            if (done) begin
                chk("done_cycle", cyc, 2 * D + 1 + stalls);
                chk("count", count, q.size());
                chk("truth_table", truth_table, f);
                chk("streamed", idx, q.size());
                fin = 1;
            end
        end
        if (!fin) chk("timeout", 0, 1);
        start = 1'b0;
        m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle", {busy, done, m_valid}, 0);
            chk("tt_held", truth_table, f);
            chk("count_held", count, q.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_ctl", {m_valid, m_data, m_last, busy, done, probe}, 0);
        chk("reset_dat", {truth_table, count}, 0);
        rst_n = 1'b1;
        run(16'h29AF, 0, 0, 0);
        run(16'h29AF, 2, 0, 0);
        run(16'h0000, 0, 0, 0);
        run(16'hFFFF, 0, 0, 0);
        run(16'h29AF, 0, 1, 0);
        run(16'h29AF, 0, 0, 1);
        run(16'h29AF, 0, 0, 0);
        run(16'h8001, 1, 0, 0);
        repeat (6) run(16'($urandom), 1, 0, 0);
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
